// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// The mode encoding is visible on the top-level 'mode' port.
package shifter_pkg;

    typedef enum logic [1:0] {
        ModeSll = 2'b00,
        ModeSrl = 2'b01,
        ModeSra = 2'b10,
        ModeRor = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/mux_2_1.sv
// Generic two-input multiplexer cell, W bits wide.
module mux_2_1 #(
    parameter int unsigned W = 1
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/shift_stage.sv
// One log level of the barrel shifter: optional shift by 2**Level, then one pipeline register
// carrying valid, data, mode, shift amount and overshift to the next level.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned Level = 0,
    localparam int unsigned L    = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [N-1:0]  data_i,
    input  shift_mode_t   mode_i,
    input  logic [L-1:0]  amt_i,
    input  logic          ovs_i,
    output logic          valid_o,
    output logic [N-1:0]  data_o,
    output shift_mode_t   mode_o,
    output logic [L-1:0]  amt_o,
    output logic          ovs_o
);

    localparam int unsigned S = 2 ** Level;

    logic         fill;
    logic         force_fill;
    logic [N-1:0] shifted;
    logic [N-1:0] stepped;
    logic [N-1:0] fill_vec;
    logic [N-1:0] data_d;

    logic         valid_q;
    logic [N-1:0] data_q;
    shift_mode_t  mode_q;
    logic [L-1:0] amt_q;
    logic         ovs_q;

    assign fill     = (mode_i == ModeSra) & data_i[N-1];
    assign fill_vec = {N{fill}};
    // Rotation ignores the upper amount bits; every other mode saturates to the fill pattern.
    assign force_fill = ovs_i & (mode_i != ModeRor);

    always_comb begin
        shifted = data_i;
        unique case (mode_i)
            ModeSll:          shifted = {data_i[N-1-S:0], {S{1'b0}}};
            ModeSrl, ModeSra: shifted = {{S{fill}}, data_i[N-1:S]};
            ModeRor:          shifted = {data_i[S-1:0], data_i[N-1:S]};
        endcase
    end

    mux_2_1 #(.W(N)) u_mux_shift (
        .sel_i (amt_i[Level]),
        .in0_i (data_i),
        .in1_i (shifted),
        .out_o (stepped)
    );

    mux_2_1 #(.W(N)) u_mux_fill (
        .sel_i (force_fill),
        .in0_i (stepped),
        .in1_i (fill_vec),
        .out_o (data_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= ModeSll;
            amt_q   <= '0;
            ovs_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            mode_q  <= mode_i;
            amt_q   <= amt_i;
            ovs_q   <= ovs_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign mode_o  = mode_q;
    assign amt_o   = amt_q;
    assign ovs_o   = ovs_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter (SLL/SRL/SRA/ROR), one register per log level, with a
// valid/ready handshake where a stalled output freezes the whole pipeline.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         overshift
);

    localparam int unsigned L = $clog2(N);

    logic         valid_s [L+1];
    logic [N-1:0] data_s  [L+1];
    shift_mode_t  mode_s  [L+1];
    logic [L-1:0] amt_s   [L+1];
    logic         ovs_s   [L+1];

    logic stall;
    logic unused_tail;

    assign stall    = valid_s[L] & ~out_ready;
    assign in_ready = ~stall;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = a;
    assign mode_s[0]  = shift_mode_t'(mode);
    assign amt_s[0]   = b[L-1:0];
    assign ovs_s[0]   = |b[N-1:L];

    for (genvar i = 0; i < L; i++) begin : g_stage
        shift_stage #(
            .N     (N),
            .Level (i)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .en_i    (in_ready),
            .valid_i (valid_s[i]),
            .data_i  (data_s[i]),
            .mode_i  (mode_s[i]),
            .amt_i   (amt_s[i]),
            .ovs_i   (ovs_s[i]),
            .valid_o (valid_s[i+1]),
            .data_o  (data_s[i+1]),
            .mode_o  (mode_s[i+1]),
            .amt_o   (amt_s[i+1]),
            .ovs_o   (ovs_s[i+1])
        );
    end

    assign out_valid = valid_s[L];
    assign out       = data_s[L];
    assign overshift = ovs_s[L];

    // Mode and amount are consumed by the last level and have no reader beyond it.
    assign unused_tail = ^{mode_s[L], amt_s[L]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (N=8) with a scoreboard queue of expected results.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;
    import shifter_pkg::*;

    localparam int unsigned N = 8;
    localparam logic [N-1:0] NV = N;

    typedef struct packed {
        logic [N-1:0] res;
        logic         ovs;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out;
    logic         overshift;

    exp_t sb[$];
    int   out_cyc[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t mon_e;

    barrel_shifter_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overshift (overshift)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovs = o;
        return e;
    endfunction

    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic [1:0] m);
        exp_t e;
        logic [N-1:0] sh;
        e.ovs = (bv >= NV);
        sh = bv & (NV - 1'b1);
        case (m)
            2'b00:   e.res = e.ovs ? '0 : av << bv;
            2'b01:   e.res = e.ovs ? '0 : av >> bv;
            2'b10:   e.res = e.ovs ? {N{av[N-1]}} : N'($signed(av) >>> bv);
            default: e.res = (av >> sh) | (av << (NV - sh));
        endcase
        return e;
    endfunction

    // Output side of the scoreboard: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("out", 32'(out), 32'(mon_e.res));
                check("overshift", 32'(overshift), 32'(mon_e.ovs));
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [1:0] m,
                        input exp_t e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = av;
        b = bv;
        mode = m;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (in_ready) begin
            sb.push_back(e);
            acc_cyc = cyc;
        end else begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_latency(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check(tag, 32'(cyc - acc_cyc), 32'd3);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n0;
        int accepted;
        logic [N-1:0] held;
        logic held_ovs;
        logic [N-1:0] ra, rb;
        logic [1:0] rm;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_overshift", 32'(overshift), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single request latency
        send(8'hB4, 8'd3, ModeSrl, mk(8'h16, 1'b0));
        idle();
        wait_latency("latency_srl");
        drain();

        // Directed function and boundary cases
        send(8'hB4, 8'd2,  ModeSra, mk(8'hED, 1'b0));
        send(8'h80, 8'h10, ModeSra, mk(8'hFF, 1'b1));
        send(8'hB4, 8'd4,  ModeRor, mk(8'h4B, 1'b0));
        send(8'hB4, 8'd12, ModeRor, mk(8'h4B, 1'b1));
        send(8'hB4, 8'd9,  ModeSll, mk(8'h00, 1'b1));
        send(8'hB4, 8'd8,  ModeSrl, mk(8'h00, 1'b1));
        send(8'h5A, 8'd7,  ModeSra, mk(8'h00, 1'b0));
        send(8'h96, 8'd0,  ModeSll, mk(8'h96, 1'b0));
        send(8'h96, 8'd0,  ModeSrl, mk(8'h96, 1'b0));
        send(8'h96, 8'd0,  ModeSra, mk(8'h96, 1'b0));
        send(8'h96, 8'd0,  ModeRor, mk(8'h96, 1'b0));
        send(8'h01, 8'd7,  ModeSll, mk(8'h80, 1'b0));
        idle();
        drain();

        // Back-to-back: 8 requests, 8 results on consecutive cycles
        n0 = out_cyc.size();
        for (int i = 0; i < 8; i++) begin
            ra = N'($urandom);
            rb = N'($urandom_range(0, 15));
            rm = 2'($urandom_range(0, 3));
            send(ra, rb, rm, model(ra, rb, rm));
        end
        idle();
        drain();
        check("b2b_count", 32'(out_cyc.size() - n0), 32'd8);
        if (out_cyc.size() - n0 == 8)
            check("b2b_consecutive", 32'(out_cyc[n0+7] - out_cyc[n0]), 32'd7);

        // Backpressure: 4 offers with out_ready low, only 3 fit
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            ra = N'($urandom);
            rb = N'($urandom_range(0, 7));
            rm = 2'(i);
            in_valid = 1'b1;
            a = ra;
            b = rb;
            mode = rm;
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                sb.push_back(model(ra, rb, rm));
            end
            if (i == 3) begin
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
        end
        idle();
        check("bp_accepted", 32'(accepted), 32'd3);
        held = out;
        held_ovs = overshift;
        n0 = out_cyc.size();
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_out", 32'(out), 32'(held));
            check("bp_hold_ovs", 32'(overshift), 32'(held_ovs));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("bp_drained", 32'(out_cyc.size() - n0), 32'd3);

        // Reset with requests in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h0F, 8'd1, ModeSll, mk(8'h1E, 1'b0));
        send(8'hC3, 8'd2, ModeRor, mk(8'hF0, 1'b0));
        idle();
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        n0 = out_cyc.size();
        repeat (6) @(negedge clk);
        check("no_stale", 32'(out_cyc.size() - n0), 32'd0);
        send(8'hB4, 8'd3, ModeSrl, mk(8'h16, 1'b0));
        idle();
        wait_latency("latency_after_rst");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
